// File: rtl/imager_pkg.sv
// Shared imager definitions: default geometry, derived accumulator widths, centroid FSM states.
package imager_pkg;

    localparam int unsigned DEF_MAX_RESOLUTION = 112;
    localparam int unsigned DEF_PIXEL_WIDTH    = 8;
    localparam int unsigned DEF_COORD_WIDTH    = 7;

    localparam int unsigned CNT_WIDTH = 2 * DEF_COORD_WIDTH;
    localparam int unsigned SUM_WIDTH = 3 * DEF_COORD_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The first bit is produced on the start edge, so done is registered
// DIVIDEND_WIDTH-1 clocks after start and quotient is valid from then on.
module seq_divider #(
    parameter int unsigned DIVIDEND_WIDTH = 21,
    parameter int unsigned DIVISOR_WIDTH  = 14,
    parameter int unsigned QUOTIENT_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      done,
    output logic [QUOTIENT_WIDTH-1:0] quotient
);

    localparam int unsigned STEP_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  rem;
    logic [DIVISOR_WIDTH-1:0]  dvsr;
    logic [DIVIDEND_WIDTH-1:0] quot;
    logic [STEP_WIDTH-1:0]     steps;
    logic                      running;

    logic [DIVISOR_WIDTH-1:0]  rem_in;
    logic [DIVISOR_WIDTH-1:0]  dvsr_in;
    logic [DIVIDEND_WIDTH-1:0] quot_in;
    logic [DIVISOR_WIDTH:0]    trial;
    logic [DIVISOR_WIDTH-1:0]  rem_step;
    logic [DIVIDEND_WIDTH-1:0] quot_step;

    assign quotient = quot[QUOTIENT_WIDTH-1:0];

    // One restoring step; a start seeds the step with the fresh operands.
    always_comb begin
        rem_in    = start ? '0 : rem;
        quot_in   = start ? dividend : quot;
        dvsr_in   = start ? divisor : dvsr;
        trial     = {rem_in, quot_in[DIVIDEND_WIDTH-1]};
        quot_step = {quot_in[DIVIDEND_WIDTH-2:0], 1'b0};
        rem_step  = trial[DIVISOR_WIDTH-1:0];
        if (trial >= {1'b0, dvsr_in}) begin
            rem_step     = DIVISOR_WIDTH'(trial - {1'b0, dvsr_in});
            quot_step[0] = 1'b1;
        end
    end

    // Iteration registers and the single-cycle completion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem     <= '0;
            dvsr    <= '0;
            quot    <= '0;
            steps   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= rem_step;
                quot    <= quot_step;
                dvsr    <= divisor;
                steps   <= STEP_WIDTH'(DIVIDEND_WIDTH - 1);
                running <= 1'b1;
            end else if (running) begin
                rem   <= rem_step;
                quot  <= quot_step;
                steps <= steps - STEP_WIDTH'(1);
                if (steps == STEP_WIDTH'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pupil_centroid.sv
// Dark-pixel centroid per frame: accumulates count and row/column sums of
// pixels below the threshold, then divides to locate the pupil.
// Optional macro PUPIL_ADAPTIVE_THRESH_EN: threshold becomes an offset above
// the previous frame's minimum pixel value (saturating).
module pupil_centroid
    import imager_pkg::*;
#(
    parameter int unsigned MAX_RESOLUTION = DEF_MAX_RESOLUTION,
    parameter int unsigned PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
    parameter int unsigned COORD_WIDTH    = DEF_COORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_capture_start,
    input  logic                     frame_capture_done,
    input  logic                     pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]   pixel_data,
    input  logic [COORD_WIDTH-1:0]   pixel_row,
    input  logic [COORD_WIDTH-1:0]   pixel_col,
    input  logic [PIXEL_WIDTH-1:0]   threshold,
    input  logic [2*COORD_WIDTH-1:0] min_count,
    output logic [COORD_WIDTH-1:0]   pupil_location_horizontal,
    output logic [COORD_WIDTH-1:0]   pupil_location_vertical,
    output logic                     pupil_valid,
    output logic                     result_strobe,
    output logic                     busy
);

    localparam int unsigned CNT_W = 2 * COORD_WIDTH;
    localparam int unsigned SUM_W = 3 * COORD_WIDTH;

    state_t                 state;
    logic [CNT_W-1:0]       count, count_next;
    logic [SUM_W-1:0]       sum_col, sum_col_next;
    logic [SUM_W-1:0]       sum_row, sum_row_next;
    logic [PIXEL_WIDTH-1:0] eff_threshold;
    logic                   pixel_in_range;
    logic                   pixel_dark;
    logic                   accumulate;
    logic                   frame_end;
    logic                   result_skip;
    logic                   div_start;
    logic                   done_col, done_row;
    logic [COORD_WIDTH-1:0] quot_col, quot_row;

    assign pixel_in_range = pixel_valid
                          && (32'(pixel_row) < MAX_RESOLUTION)
                          && (32'(pixel_col) < MAX_RESOLUTION);
    assign pixel_dark  = pixel_in_range && (pixel_data < eff_threshold);
    assign accumulate  = frame_capture_start || (state == ACCUM);
    assign frame_end   = (state == ACCUM) && frame_capture_done && !frame_capture_start;
    assign result_skip = (count_next == '0) || (count_next < min_count);
    assign div_start   = frame_end && !result_skip;

    // Next accumulator values: a start clears first, then the current pixel adds in.
    always_comb begin
        count_next   = frame_capture_start ? '0 : count;
        sum_col_next = frame_capture_start ? '0 : sum_col;
        sum_row_next = frame_capture_start ? '0 : sum_row;
        if (pixel_dark) begin
            count_next   = count_next + CNT_W'(1);
            sum_col_next = sum_col_next + SUM_W'(pixel_col);
            sum_row_next = sum_row_next + SUM_W'(pixel_row);
        end
    end

`ifdef PUPIL_ADAPTIVE_THRESH_EN
    logic [PIXEL_WIDTH-1:0] frame_min, frame_min_next, prev_min;
    logic                   prev_min_valid;
    logic [PIXEL_WIDTH:0]   thr_sum;

    assign thr_sum       = {1'b0, prev_min} + {1'b0, threshold};
    assign eff_threshold = !prev_min_valid ? threshold
                         : (thr_sum[PIXEL_WIDTH] ? '1 : thr_sum[PIXEL_WIDTH-1:0]);

    // Running minimum including the pixel in flight this cycle.
    always_comb begin
        frame_min_next = frame_capture_start ? '1 : frame_min;
        if (pixel_in_range && (pixel_data < frame_min_next)) begin
            frame_min_next = pixel_data;
        end
    end

    // Frame minimum tracking; only a completed frame updates the reference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_min      <= '1;
            prev_min       <= '0;
            prev_min_valid <= 1'b0;
        end else begin
            if (accumulate) begin
                frame_min <= frame_min_next;
            end
            if (frame_end) begin
                prev_min       <= frame_min_next;
                prev_min_valid <= 1'b1;
            end
        end
    end
`else
    assign eff_threshold = threshold;
`endif

    seq_divider #(
        .DIVIDEND_WIDTH(SUM_W),
        .DIVISOR_WIDTH (CNT_W),
        .QUOTIENT_WIDTH(COORD_WIDTH)
    ) u_div_col (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(sum_col_next),
        .divisor (count_next),
        .done    (done_col),
        .quotient(quot_col)
    );

    seq_divider #(
        .DIVIDEND_WIDTH(SUM_W),
        .DIVISOR_WIDTH (CNT_W),
        .QUOTIENT_WIDTH(COORD_WIDTH)
    ) u_div_row (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(sum_row_next),
        .divisor (count_next),
        .done    (done_row),
        .quotient(quot_row)
    );

    // Frame FSM with accumulators and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            count                     <= '0;
            sum_col                   <= '0;
            sum_row                   <= '0;
            pupil_location_horizontal <= '0;
            pupil_location_vertical   <= '0;
            pupil_valid               <= 1'b0;
            result_strobe             <= 1'b0;
            busy                      <= 1'b0;
        end else begin
            result_strobe <= 1'b0;
            if (accumulate) begin
                count   <= count_next;
                sum_col <= sum_col_next;
                sum_row <= sum_row_next;
            end
            case (state)
                IDLE: begin
                    if (frame_capture_start) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (frame_end) begin
                        if (result_skip) begin
                            pupil_valid   <= 1'b0;
                            result_strobe <= 1'b1;
                            state         <= IDLE;
                            busy          <= 1'b0;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (frame_capture_start) begin
                        state <= ACCUM;
                    end else if (done_col && done_row) begin
                        pupil_location_horizontal <= quot_col;
                        pupil_location_vertical   <= quot_row;
                        pupil_valid               <= 1'b1;
                        result_strobe             <= 1'b1;
                        state                     <= IDLE;
                        busy                      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pupil_centroid.sv
// Directed and randomized frames for pupil_centroid, checked against a
// frame-level reference model (pixel list -> count/sums -> truncating mean).
module tb_pupil_centroid;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_capture_start;
    logic       frame_capture_done;
    logic       pixel_valid;
    logic [7:0] pixel_data;
    logic [6:0] pixel_row;
    logic [6:0] pixel_col;
    logic [7:0] threshold;
    logic [13:0] min_count;
    logic [6:0] pupil_location_horizontal;
    logic [6:0] pupil_location_vertical;
    logic       pupil_valid;
    logic       result_strobe;
    logic       busy;

    pupil_centroid dut (
        .clk                      (clk),
        .reset                    (reset),
        .frame_capture_start      (frame_capture_start),
        .frame_capture_done       (frame_capture_done),
        .pixel_valid              (pixel_valid),
        .pixel_data               (pixel_data),
        .pixel_row                (pixel_row),
        .pixel_col                (pixel_col),
        .threshold                (threshold),
        .min_count                (min_count),
        .pupil_location_horizontal(pupil_location_horizontal),
        .pupil_location_vertical  (pupil_location_vertical),
        .pupil_valid              (pupil_valid),
        .result_strobe            (result_strobe),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } pix_t;

    pix_t frame_q[$];
    bit   in_frame;
    int   exp_h, exp_v, exp_valid;
    int   pend_h, pend_v, pend_valid, pend_lat;
`ifdef PUPIL_ADAPTIVE_THRESH_EN
    int   prev_min;
    bit   have_prev;
`endif
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic model_reset();
        frame_q.delete();
        in_frame  = 0;
        exp_h     = 0;
        exp_v     = 0;
        exp_valid = 0;
`ifdef PUPIL_ADAPTIVE_THRESH_EN
        have_prev = 0;
        prev_min  = 0;
`endif
    endtask

    // End of frame: mean of dark in-range pixel coordinates, or a skip.
    task automatic model_done();
        int cnt, sc, sr, eff, fmin;
        cnt = 0; sc = 0; sr = 0; fmin = 255;
        eff = int'(threshold);
`ifdef PUPIL_ADAPTIVE_THRESH_EN
        if (have_prev) eff = (prev_min + int'(threshold) > 255) ? 255 : prev_min + int'(threshold);
`endif
        foreach (frame_q[i]) begin
            if (frame_q[i].row < 112 && frame_q[i].col < 112) begin
                if (frame_q[i].data < fmin) fmin = frame_q[i].data;
                if (frame_q[i].data < eff) begin
                    cnt++;
                    sc += frame_q[i].col;
                    sr += frame_q[i].row;
                end
            end
        end
        if (cnt == 0 || cnt < int'(min_count)) begin
            pend_valid = 0;
            pend_lat   = 1;
        end else begin
            pend_valid = 1;
            pend_h     = sc / cnt;
            pend_v     = sr / cnt;
            pend_lat   = 22;
        end
`ifdef PUPIL_ADAPTIVE_THRESH_EN
        prev_min  = fmin;
        have_prev = 1;
`endif
    endtask

    // One clock of stimulus, mirrored into the model's frame pixel list.
    task automatic drive(input bit s, input bit d, input bit v, input int r, input int c, input int px);
        pix_t p;
        @(negedge clk);
        frame_capture_start = s;
        frame_capture_done  = d;
        pixel_valid         = v;
        pixel_row           = 7'(r);
        pixel_col           = 7'(c);
        pixel_data          = 8'(px);
        if (s) begin
            frame_q.delete();
            in_frame = 1;
        end
        if (v && in_frame) begin
            p.row = r; p.col = c; p.data = px;
            frame_q.push_back(p);
        end
        if (d && in_frame && !s) begin
            model_done();
            in_frame = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic bright(input int n);
        for (int i = 0; i < n; i++)
            drive(0, 0, 1, $urandom_range(0, 111), $urandom_range(0, 111), 200);
    endtask

    // Wait (bounded) for the strobe after a done, then compare everything.
    task automatic wait_result(input string tag);
        int lat;
        bit seen;
        lat = 0; seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (k == 5 && pend_lat == 22) check({tag, "_busy_div"}, 32'(busy), 1);
            if (result_strobe) begin
                seen = 1;
                lat  = k;
            end
        end
        check({tag, "_strobe_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, 32'(lat), 32'(pend_lat));
        if (pend_valid != 0) begin
            exp_h = pend_h;
            exp_v = pend_v;
        end
        exp_valid = pend_valid;
        check({tag, "_h"}, 32'(pupil_location_horizontal), 32'(exp_h));
        check({tag, "_v"}, 32'(pupil_location_vertical), 32'(exp_v));
        check({tag, "_valid"}, 32'(pupil_valid), 32'(exp_valid));
        check({tag, "_busy_done"}, 32'(busy), 0);
        drive(0, 0, 0, 0, 0, 0);
        check({tag, "_strobe_single"}, 32'(result_strobe), 0);
    endtask

    initial begin
        bit strobe_any;
        int n;

        reset = 1'b1;
        frame_capture_start = 0; frame_capture_done = 0; pixel_valid = 0;
        pixel_data = 0; pixel_row = 0; pixel_col = 0;
        threshold = 8'd50; min_count = 14'd4;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_h", 32'(pupil_location_horizontal), 0);
        check("rst_v", 32'(pupil_location_vertical), 0);
        check("rst_valid", 32'(pupil_valid), 0);
        check("rst_strobe", 32'(result_strobe), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // Pixels and done while idle have no effect.
        drive(0, 0, 1, 10, 10, 5);
        drive(0, 1, 1, 11, 11, 5);
        strobe_any = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            strobe_any |= result_strobe;
        end
        check("idle_no_strobe", 32'(strobe_any), 0);
        check("idle_busy", 32'(busy), 0);

        // 3x3 dark block at rows 40-42, cols 60-62 among bright pixels.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("accum_busy", 32'(busy), 1);
        bright(20);
        for (int r = 40; r <= 42; r++)
            for (int c = 60; c <= 62; c++) begin
                drive(0, 0, 1, r, c, 10);
                bright(3);
            end
        drive(0, 1, 0, 0, 0, 0);
        wait_result("block");
        check("block_h_const", 32'(pupil_location_horizontal), 61);
        check("block_v_const", 32'(pupil_location_vertical), 41);

        // Single dark pixel below min_count: skip and hold locations.
        drive(1, 0, 0, 0, 0, 0);
        bright(10);
        drive(0, 0, 1, 5, 5, 10);
        bright(10);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("below_min");
        check("below_min_h_hold", 32'(pupil_location_horizontal), 61);
        check("below_min_v_hold", 32'(pupil_location_vertical), 41);

        // Truncation, out-of-range column, pixel coincident with done.
        min_count = 14'd2;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 10, 10, 10);
        drive(0, 0, 1, 11, 112, 10);
        drive(0, 1, 1, 11, 11, 10);
        wait_result("trunc");
        check("trunc_h_const", 32'(pupil_location_horizontal), 10);
        check("trunc_v_const", 32'(pupil_location_vertical), 10);

        // Mid-frame restart: only the second frame counts.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 100, 100, 10);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 20, 30, 10);
        drive(0, 0, 1, 22, 32, 10);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("restart");
        check("restart_h_const", 32'(pupil_location_horizontal), 31);

        // Start during DIVIDE aborts: no strobe, outputs unchanged.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 50, 50, 10);
        drive(0, 1, 1, 52, 52, 10);
        strobe_any = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            strobe_any |= result_strobe;
        end
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            strobe_any |= result_strobe;
        end
        check("abort_no_strobe", 32'(strobe_any), 0);
        check("abort_h_hold", 32'(pupil_location_horizontal), 31);
        check("abort_v_hold", 32'(pupil_location_vertical), 21);
        check("abort_busy", 32'(busy), 1);
        drive(0, 0, 1, 70, 80, 10);
        drive(0, 0, 1, 71, 81, 10);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("after_abort");

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            threshold = 8'($urandom_range(20, 150));
            min_count = 14'($urandom_range(1, 8));
            n = $urandom_range(5, 40);
            drive(1, 0, 0, 0, 0, 0);
            for (int i = 0; i < n; i++)
                drive(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 119),
                      $urandom_range(0, 119), $urandom_range(0, 255));
            drive(0, 1, $urandom_range(0, 1) != 0, $urandom_range(0, 111),
                  $urandom_range(0, 111), $urandom_range(0, 255));
            wait_result($sformatf("rand%0d", f));
        end

`ifdef PUPIL_ADAPTIVE_THRESH_EN
        // Minimum 20 + 15 -> next frame counts values below 35.
        threshold = 8'd15;
        min_count = 14'd1;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 20);
        drive(0, 0, 1, 2, 2, 100);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("adapt_a");
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 10, 10, 34);
        drive(0, 0, 1, 12, 12, 30);
        drive(0, 0, 1, 50, 50, 35);
        drive(0, 0, 1, 60, 60, 40);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("adapt_b");
        check("adapt_b_h_const", 32'(pupil_location_horizontal), 11);
        // Minimum 250 + 15 saturates to 255.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 3, 250);
        drive(0, 0, 1, 4, 4, 251);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("adapt_c");
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 20, 20, 254);
        drive(0, 0, 1, 90, 90, 255);
        drive(0, 0, 1, 22, 22, 254);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("adapt_d");
        check("adapt_d_h_const", 32'(pupil_location_horizontal), 21);
`endif

        // Reset in cycle 10 of DIVIDE clears everything at once.
        threshold = 8'd50;
        min_count = 14'd1;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 40, 40, 10);
        drive(0, 1, 1, 44, 44, 10);
        idle(9);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_h", 32'(pupil_location_horizontal), 0);
        check("mid_rst_v", 32'(pupil_location_vertical), 0);
        check("mid_rst_valid", 32'(pupil_valid), 0);
        check("mid_rst_strobe", 32'(result_strobe), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 4, 10);
        drive(0, 0, 1, 5, 6, 10);
        drive(0, 1, 0, 0, 0, 0);
        wait_result("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pupil_centroid.md
Name: pupil_centroid

Overview:
- Parametrised successor to the fixed-resolution pupil detector on each camera channel.
- Consumes the per-pixel stream from the ADC controller: pixel value plus row/column from the Stonyman controller.
- Accumulates the count and coordinate sums of "dark" pixels over one frame, then computes the centroid with a sequential divider.
- Reports the pupil location to the APB interface once per frame.

Parameters:
- MAX_RESOLUTION, 112: pixels per row/column; coordinates at or above this value are ignored.
- PIXEL_WIDTH, 8: pixel value width.
- COORD_WIDTH, 7: row/column width; must satisfy 2^COORD_WIDTH >= MAX_RESOLUTION.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_capture_start  in  1  single-cycle pulse; clears the accumulators and starts a frame.
- frame_capture_done  in  1  single-cycle pulse; ends the frame and starts the divide.
- pixel_valid  in  1  single-cycle qualifier for pixel_data, pixel_row and pixel_col.
- pixel_data  in  PIXEL_WIDTH  pixel value.
- pixel_row  in  COORD_WIDTH  pixel row.
- pixel_col  in  COORD_WIDTH  pixel column.
- threshold  in  PIXEL_WIDTH  a pixel is dark when pixel_data < effective threshold.
- min_count  in  2*COORD_WIDTH  minimum dark-pixel count for a valid result.
- pupil_location_horizontal  out  COORD_WIDTH  centroid column.
- pupil_location_vertical  out  COORD_WIDTH  centroid row.
- pupil_valid  out  1  the last frame met min_count.
- result_strobe  out  1  single-cycle pulse when the outputs update.
- busy  out  1  high in the ACCUM and DIVIDE states.

Behaviour:
- Internal widths:
  - CNT_WIDTH = 2*COORD_WIDTH.
  - SUM_WIDTH = 3*COORD_WIDTH.
  - No overflow is possible at MAX_RESOLUTION.
- Reset: all outputs are 0; the state machine goes to IDLE; the accumulators and frame minimum are cleared.
- State machine: IDLE -> ACCUM -> DIVIDE -> IDLE.
- IDLE:
  - frame_capture_start -> ACCUM.
  - pixel_valid is ignored.
  - frame_capture_done is ignored.
- ACCUM, for each pixel with pixel_valid=1, pixel_row<MAX_RESOLUTION, pixel_col<MAX_RESOLUTION and pixel_data<threshold:
  - count += 1.
  - sum_col += pixel_col.
  - sum_row += pixel_row.
- ACCUM transitions:
  - frame_capture_start again: accumulators clear and ACCUM restarts (mid-frame restart).
  - frame_capture_done -> DIVIDE.
- Simultaneous events:
  - frame_capture_start with pixel_valid in the same cycle: the accumulators clear and the pixel is counted as the first pixel of the new frame.
  - frame_capture_done with pixel_valid in the same cycle: the pixel is included before the divide.
- Divide decision:
  - count < min_count, or count == 0: the divide is skipped; pupil_valid=0; both locations hold their previous values; result_strobe pulses the cycle after done.
  - Otherwise: sum_col/count and sum_row/count are computed in parallel by restoring division, one quotient bit per cycle, truncating.
- Divide latency:
  - done is sampled in cycle 0; DIVIDE occupies cycles 1..SUM_WIDTH.
  - In cycle SUM_WIDTH+1 the locations register, pupil_valid=1 and result_strobe pulses for 1 cycle.
  - At defaults this is cycle 22.
- DIVIDE:
  - pixel_valid and frame_capture_done are ignored.
  - frame_capture_start aborts the divide: outputs are unchanged, no strobe, -> ACCUM with cleared accumulators.
- Output range: the quotient is always < MAX_RESOLUTION; it is truncated to COORD_WIDTH.
- busy = (state != IDLE).

Optional Feature:
- Macro: PUPIL_ADAPTIVE_THRESH_EN.
- When defined:
  - The block tracks the minimum valid pixel_data of each frame.
  - Effective threshold = previous-frame minimum + threshold, saturating at 2^PIXEL_WIDTH-1.
  - The minimum register is latched at frame_capture_done.
  - The first frame after reset uses threshold directly.
  - An aborted frame does not update the minimum.
- When undefined: effective threshold = threshold, and no minimum logic is synthesised.

Decomposition:
- Shared package imager_pkg holds:
  - MAX_RESOLUTION, PIXEL_WIDTH, COORD_WIDTH defaults.
  - Derived CNT_WIDTH and SUM_WIDTH.
  - The state enum (IDLE/ACCUM/DIVIDE).
- One natural sub-module, seq_divider:
  - Parametrised restoring divider with start, done, dividend, divisor and quotient.
  - Instantiated twice (row and column).

Test Plan:
- Dark block: 3x3 block of value 10 at rows 40-42, cols 60-62; all other pixels 200; threshold=50; min_count=4 -> h=61, v=41, pupil_valid=1; result_strobe exactly 22 cycles after frame_capture_done.
- Below minimum: single dark pixel; min_count=4 -> pupil_valid=0; locations hold the prior 61/41; strobe 1 cycle after done.
- Truncation and edges:
  - Dark pixels at (10,10) and (11,11) -> h=10, v=10.
  - Pixel at col 112 is ignored.
  - Dark pixel coincident with done is counted.
- Restarts:
  - frame_capture_start mid-ACCUM, then a clean frame -> result reflects only the second frame.
  - start during DIVIDE -> no strobe, outputs unchanged.
- Mid-divide reset: assert reset at cycle 10 of DIVIDE -> all outputs 0 immediately, state IDLE, busy=0.
- Adaptive (with PUPIL_ADAPTIVE_THRESH_EN):
  - Frame minimum 20, threshold=15 -> the next frame counts pixels <35 only.
  - Frame minimum 250, threshold=15 -> effective threshold saturates at 255.
